// File: rtl/sdiv_select_seq.sv
// sdiv_select_seq
//   Multicycle signed divide/select unit. One restoring divider is shared by
//   two divisions:
//     e = a / b, g = a % b   (first pass)
//     f = c / d              (second pass)
//   After both passes it registers z = (g == zero) ? f : e.
//   Division by zero gives quotient 0 and remainder = dividend. The dbz output
//   flags a zero divisor in the operation that just finished.
//   MIN / -1 wraps to MIN with remainder 0.
//
// Optional build macro:
//   SDIV_SELECT_EARLY_EXIT_EN - if g != zero after the first pass, f cannot be
//     selected. The second pass is then skipped and only b==0 feeds dbz.
//
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   start          operation request; only sampled while idle
//   a, b, c, d     signed dividends and divisors, latched on the start edge
//   zero           signed compare value for g, latched on the start edge
//   busy           high while an operation is in flight
//   done           one-cycle pulse when z and dbz update
//   z              selected signed result, held between operations
//   dbz            divide-by-zero flag for the last operation
module sdiv_select_seq #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] d,
  input  logic [DATAWIDTH-1:0] zero,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] z,
  output logic                 dbz
);

  localparam int W = DATAWIDTH;
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [6:0]   LAST = 7'(W - 1);

  typedef enum logic [1:0] {IDLE, DIV_AB, DIV_CD, SEL} state_t;

  state_t state_q, state_d;

  logic [W-1:0] a_q, b_q, c_q, d_q, zero_q;
  logic [W-1:0] e_q, f_q, g_q;
  logic [W:0]   rem_q;   // partial remainder, one bit wider for the compare
  logic [W-1:0] quo_q;   // dividend magnitude shifting out, quotient shifting in
  logic [6:0]   cnt_q;

  // Two's-complement magnitude. The result is read as unsigned, so |MIN|
  // (a single 1 in the MSB) still fits in W bits.
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    mag = x[W-1] ? (~x + ONE) : x;
  endfunction

  // Operand pair for the pass that is currently running.
  logic         cd_phase;
  logic [W-1:0] dvd_op, dvs_op;
  logic [W:0]   dvs_ext, rem_sh, rem_nx;
  logic [W-1:0] quo_nx, q_s, r_s, q_fin, r_fin;
  logic         ge, last, div0;

  always_comb begin
    cd_phase = (state_q == DIV_CD);
    dvd_op   = cd_phase ? c_q : a_q;
    dvs_op   = cd_phase ? d_q : b_q;
    dvs_ext  = {1'b0, mag(dvs_op)};
    // One restoring step. Bring down the next dividend bit, then subtract if
    // the result would not go negative.
    rem_sh   = {rem_q[W-1:0], quo_q[W-1]};
    ge       = (rem_sh >= dvs_ext);
    rem_nx   = ge ? (rem_sh - dvs_ext) : rem_sh;
    quo_nx   = {quo_q[W-2:0], ge};
    last     = (cnt_q == LAST);
    // Restore the signs. Quotient truncates toward zero. Remainder follows the
    // sign of the dividend.
    q_s      = (dvd_op[W-1] ^ dvs_op[W-1]) ? (~quo_nx + ONE) : quo_nx;
    r_s      = dvd_op[W-1] ? (~rem_nx[W-1:0] + ONE) : rem_nx[W-1:0];
    div0     = (dvs_op == '0);
    q_fin    = div0 ? '0 : q_s;
    r_fin    = div0 ? dvd_op : r_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = DIV_AB;
      DIV_AB: if (last) begin
`ifdef SDIV_SELECT_EARLY_EXIT_EN
                // g != zero means e is the result, so f is not needed.
                state_d = (r_fin != zero_q) ? SEL : DIV_CD;
`else
                state_d = DIV_CD;
`endif
              end
      DIV_CD: if (last) state_d = SEL;
      SEL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      zero_q <= '0;
      e_q    <= '0;
      f_q    <= '0;
      g_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      z      <= '0;
      dbz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          a_q    <= a;
          b_q    <= b;
          c_q    <= c;
          d_q    <= d;
          zero_q <= zero;
          rem_q  <= '0;
          quo_q  <= mag(a);
          cnt_q  <= '0;
          busy   <= 1'b1;
        end
        DIV_AB: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 7'd1;
          if (last) begin
            e_q   <= q_fin;
            g_q   <= r_fin;
            // Load the c/d pass directly.
            rem_q <= '0;
            quo_q <= mag(c_q);
            cnt_q <= '0;
          end
        end
        DIV_CD: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 7'd1;
          if (last) f_q <= q_fin;
        end
        SEL: begin
          z    <= (g_q == zero_q) ? f_q : e_q;
`ifdef SDIV_SELECT_EARLY_EXIT_EN
          // The c/d pass ran only when g matched zero.
          dbz  <= (b_q == '0) | ((d_q == '0) & (g_q == zero_q));
`else
          dbz  <= (b_q == '0) | (d_q == '0);
`endif
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdiv_select_seq.sv
module tb_sdiv_select_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0, d = '0, zro = '0;
  logic       busy, done, dbz;
  logic [7:0] z;

  int nchk = 0;
  int nerr = 0;

  sdiv_select_seq #(.DATAWIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .d(d), .zero(zro),
    .busy(busy), .done(done), .z(z), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: signed division with plain integer arithmetic.
  task automatic model(input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] q, output logic [7:0] r);
    int xi, yi;
    xi = int'($signed(x));
    yi = int'($signed(y));
    if (yi == 0) begin
      q = 8'd0;
      r = x;
    end else begin
      q = 8'(xi / yi);
      r = 8'(xi % yi);
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                        input logic [7:0] tc, input logic [7:0] td,
                        input logic [7:0] tz, input bit poke);
    logic [7:0] e, g, f, junk, ez;
    bit edbz, busy_ok, seen;
    int lat, n, extra;
    model(ta, tb, e, g);
    model(tc, td, f, junk);
    ez = (g == tz) ? f : e;
`ifdef SDIV_SELECT_EARLY_EXIT_EN
    lat  = (g == tz) ? 17 : 9;
    edbz = (tb == 8'd0) || ((td == 8'd0) && (g == tz));
`else
    lat  = 17;
    edbz = (tb == 8'd0) || (td == 8'd0);
`endif
    a = ta; b = tb; c = tc; d = td; zro = tz; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_ok = busy;
    seen = 0;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      if (poke) begin
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        d = 8'($urandom); zro = 8'($urandom);
        start = (i == 3);
      end
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        n = i;
        break;
      end
      if (!busy) busy_ok = 0;
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", n, lat);
    chk("busy_during", busy_ok, 1);
    chk("busy_at_done", busy, 0);
    chk("z", z, ez);
    chk("dbz", dbz, edbz);
    if (poke) begin
      extra = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      chk("extra_done", extra, 0);
    end
  endtask

  initial begin
    logic [7:0] ra, rb, rc, rd, rz, e, g;
    int extra;

    // Outputs while reset is held
    #1;
    chk("rst_z", z, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    run_op(8'd17, 8'd5, 8'd40, 8'd6, 8'd0, 0);                          // z=3 (e)
    run_op(8'd15, 8'd5, 8'($signed(-40)), 8'd6, 8'd0, 0);               // z=-6 (f)
    run_op(8'($signed(-17)), 8'd5, 8'd7, 8'd2, 8'($signed(-2)), 1);     // poke: ignored start
    run_op(8'd9, 8'd0, 8'd12, 8'd4, 8'd9, 0);                           // dbz
    run_op(8'h80, 8'hff, 8'h80, 8'hff, 8'd0, 0);                        // MIN/-1
    run_op(8'd9, 8'd4, 8'd5, 8'd0, 8'd1, 0);                            // d=0 selected
    run_op(8'h80, 8'd3, 8'h7f, 8'hfe, 8'hfe, 0);                        // MIN dividend
    // After an op that was not followed by a start, done must drop.
    @(posedge clk); #1;
    chk("done_pulse", done, 0);

    // Reset in the middle of an operation
    a = 8'd100; b = 8'd7; c = 8'd50; d = 8'd3; zro = 8'd0; start = 1'b1;
    @(posedge clk); #1;                    // E0
    start = 1'b0;
    repeat (5) @(posedge clk);             // E5
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_z", z, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("no_done_after_rst", extra, 0);
    run_op(8'd100, 8'd7, 8'd50, 8'd3, 8'd2, 0);

    // Randomised operations. Some ops start in the cycle done is high.
    for (int k = 0; k < 40; k++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      rc = 8'($urandom);
      rd = ($urandom_range(0, 5) == 0) ? 8'd0 :
           (($urandom_range(0, 7) == 0) ? 8'hff : 8'($urandom));
      model(ra, rb, e, g);
      rz = $urandom_range(0, 1) ? g : 8'($urandom);
      run_op(ra, rb, rc, rd, rz, 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sdiv_select_seq.md
Name: sdiv_select_seq

Overview:
- Sequential, parametrised successor to the combinational divide/modulo/compare/mux netlist circuits.
- Computes e = a/b, f = c/d and g = a%b with one shared iterative signed divider, then registers z = (g == zero) ? f : e.
- Sits in the netlist-behaviour datapath library. It replaces wide combinational SDIV/SMOD chains with a start/done multicycle unit, adds divide-by-zero reporting and runs at a higher clock rate.

Parameters:
- DATAWIDTH, 64, width W of all operands and of z. Legal values are 2 to 64.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  request. Sampled only in IDLE.
- a  input  W  signed dividend, quotient e and remainder g
- b  input  W  signed divisor for a
- c  input  W  signed dividend, quotient f
- d  input  W  signed divisor for c
- zero  input  W  signed compare value for g
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when z and dbz update
- z  output  W  signed result, held between operations
- dbz  output  1  divide-by-zero flag for the last operation

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: z=0, done=0, busy=0, dbz=0, FSM in IDLE, all internal registers 0.
- rst asserted mid-operation aborts the operation immediately. No done pulse is produced for it.
- FSM states and transitions:
  - IDLE: on start=1, latch a, b, c, d and zero (edge E0), go to DIV_AB, busy=1.
  - DIV_AB: W restoring-division iterations on |a|/|b|, one per edge (E1..EW). Then store e and g.
  - DIV_CD: W iterations on |c|/|d| (EW+1..E2W). Then store f.
  - SEL: at edge E2W+1, z <= (g == zero) ? f : e. Set dbz, pulse done=1, set busy=0, return to IDLE.
- Latency: 2W+1 edges from the start-sampling edge to done high (17 edges for W=8).
- done is high for exactly one cycle.
- A new start may be sampled in the same cycle that done is high, because the FSM is already in IDLE.
- start while busy=1 is ignored; the latched operands are unaffected.
- Input changes after E0 have no effect on the result.
- Arithmetic follows Verilog signed semantics:
  - quotient truncates toward zero;
  - remainder takes the sign of the dividend;
  - |quotient| and |remainder| are computed on W+1-bit magnitudes.
- Overflow: MIN/-1 gives quotient MIN (two's-complement wrap) and remainder 0. No flag is raised.
- Divisor 0: quotient = 0, remainder = dividend.
- dbz = (b==0) | (d==0), registered together with z.
- The compare g == zero is a full W-bit signed equality.

Optional Feature:
- Macro: SDIV_SELECT_EARLY_EXIT_EN.
- Defined: after DIV_AB, if g != zero, the FSM skips DIV_CD and goes straight to SEL.
  - Latency is W+1 edges when e is selected, 2W+1 when f is selected.
  - When DIV_CD is skipped, dbz = (b==0) only.
- Undefined: both divisions always run; fixed latency 2W+1 edges; dbz as in Behaviour.

Test Plan:
- W=8, a=17, b=5, c=40, d=6, zero=0, start pulse -> g=2, z=3, dbz=0; done high 17 edges after start (9 edges with SDIV_SELECT_EARLY_EXIT_EN).
- W=8, a=15, b=5, c=-40, d=6, zero=0 -> g=0, z=-6 (0xFA); busy high from E0 through E16, then low.
- W=8, a=-17, b=5, c=7, d=2, zero=-2 -> e=-3, g=-2 matches zero, z=3; second start pulsed during busy is ignored (exactly one done).
- W=8, a=9, b=0, c=12, d=4, zero=9 -> e=0, g=9 matches, z=3, dbz=1.
- W=8, a=-128, b=-1, c=-128, d=-1, zero=0 -> e=-128, g=0 selects f, z=0x80, dbz=0, no X.
- Reset mid-operation: assert rst at E5 of a W=8 run -> z=0, busy=0, done=0 asynchronously and no done follows; a fresh start after rst deasserts gives the correct result at the correct latency.
